// File: rtl/msk_aes_mc_seq_pkg.sv
// Shared constants for the masked MixColumns sequencer: GF(2^8) reduction,
// column count per state and result FIFO depth.
package msk_aes_mc_seq_pkg;

    localparam logic [7:0]  GF_RED     = 8'h1B;
    localparam int unsigned COL_COUNT  = 4;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef logic [1:0] col_idx_t;

endpackage

// File: rtl/msk_aes_mc_col.sv
// Masked one-column AES MixColumns, computed per share with no share mixing;
// bypass passes the column through unchanged (final round).
module msk_aes_mc_col
    import msk_aes_mc_seq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic           bypass,
    input  logic [8*d-1:0] b0,
    input  logic [8*d-1:0] b1,
    input  logic [8*d-1:0] b2,
    input  logic [8*d-1:0] b3,
    output logic [8*d-1:0] a0,
    output logic [8*d-1:0] a1,
    output logic [8*d-1:0] a2,
    output logic [8*d-1:0] a3
);

    localparam int W = 8*d;

    logic [W-1:0] b  [COL_COUNT];
    logic [W-1:0] xt [COL_COUNT];
    logic [W-1:0] x3 [COL_COUNT];
    logic [W-1:0] p0 [COL_COUNT];
    logic [W-1:0] p1 [COL_COUNT];
    logic [W-1:0] mc [COL_COUNT];

    assign b[0] = b0;
    assign b[1] = b1;
    assign b[2] = b2;
    assign b[3] = b3;

    // xtime per share: bit i of share j sits at i*d+j; reduction gated by the same share of bit 7
    always_comb begin
        for (int unsigned k = 0; k < COL_COUNT; k++) begin
            xt[k] = '0;
            for (int unsigned j = 0; j < d; j++) begin
                xt[k][j] = GF_RED[0] & b[k][7*d+j];
                for (int unsigned i = 1; i < 8; i++) begin
                    xt[k][i*d+j] = b[k][(i-1)*d+j] ^ (GF_RED[i] & b[k][7*d+j]);
                end
            end
        end
    end

    // a[k] = 2*b[k] ^ 3*b[k+1] ^ b[k+2] ^ b[k+3]
    for (genvar k = 0; k < COL_COUNT; k++) begin : g_row
        msk_xor #(.d(d)) u_x3 (.a(xt[k]),                 .b(b[k]),                     .y(x3[k]));
        msk_xor #(.d(d)) u_p0 (.a(xt[k]),                 .b(x3[(k+1)%COL_COUNT]),      .y(p0[k]));
        msk_xor #(.d(d)) u_p1 (.a(b[(k+2)%COL_COUNT]),    .b(b[(k+3)%COL_COUNT]),       .y(p1[k]));
        msk_xor #(.d(d)) u_mc (.a(p0[k]),                 .b(p1[k]),                    .y(mc[k]));
    end

    assign a0 = bypass ? b0 : mc[0];
    assign a1 = bypass ? b1 : mc[1];
    assign a2 = bypass ? b2 : mc[2];
    assign a3 = bypass ? b3 : mc[3];

endmodule

// File: rtl/msk_xor.sv
// Masked XOR: share-wise XOR of two Boolean-masked bytes (bit-major layout).
module msk_xor #(
    parameter int d = 2
) (
    input  logic [8*d-1:0] a,
    input  logic [8*d-1:0] b,
    output logic [8*d-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/msk_aes_mc_seq.sv
// Masked MixColumns sequencer: one column per cycle into a 2-entry result FIFO,
// tagging each entry with its column index within the state.
module msk_aes_mc_seq
    import msk_aes_mc_seq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_bypass,
    input  logic [8*d-1:0] in_b0,
    input  logic [8*d-1:0] in_b1,
    input  logic [8*d-1:0] in_b2,
    input  logic [8*d-1:0] in_b3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*d-1:0] out_a0,
    output logic [8*d-1:0] out_a1,
    output logic [8*d-1:0] out_a2,
    output logic [8*d-1:0] out_a3,
    output logic [1:0]     out_idx,
    output logic           out_last
);

    localparam int W = 8*d;

    logic [W-1:0]   c0, c1, c2, c3;
    logic [4*W-1:0] data_mem [FIFO_DEPTH];
    col_idx_t       idx_mem  [FIFO_DEPTH];
    logic           last_mem [FIFO_DEPTH];

    logic     wr_ptr, rd_ptr;
    logic [1:0] count, count_n;
    col_idx_t col_cnt;
    logic     in_ready_q;
    logic     push, pop;

    msk_aes_mc_col #(.d(d)) u_col (
        .bypass (in_bypass),
        .b0     (in_b0),
        .b1     (in_b1),
        .b2     (in_b2),
        .b3     (in_b3),
        .a0     (c0),
        .a1     (c1),
        .a2     (c2),
        .a3     (c3)
    );

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
    end

    // in_ready is registered from the next occupancy so it never depends on out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            col_cnt    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            count      <= '0;
            col_cnt    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            count      <= count_n;
            in_ready_q <= (count_n < 2'(FIFO_DEPTH));
            if (push) begin
                wr_ptr  <= ~wr_ptr;
                col_cnt <= col_cnt + 2'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr] <= {c0, c1, c2, c3};
            idx_mem[wr_ptr]  <= col_cnt;
            last_mem[wr_ptr] <= (col_cnt == 2'(COL_COUNT - 1));
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count != '0);
    assign out_idx   = out_valid ? idx_mem[rd_ptr]  : '0;
    assign out_last  = out_valid ? last_mem[rd_ptr] : 1'b0;
    assign out_a0    = data_mem[rd_ptr][4*W-1 -: W];
    assign out_a1    = data_mem[rd_ptr][3*W-1 -: W];
    assign out_a2    = data_mem[rd_ptr][2*W-1 -: W];
    assign out_a3    = data_mem[rd_ptr][W-1   -: W];

endmodule
